// File: rtl/hex_disp_pkg.sv
// Register offsets and segment decoder shared by the hex display bus slave.
// HEX_DISP_SB_RAW_SEG_EN widens the digit registers to 7 bits for raw segment drive.
package hex_disp_pkg;

    localparam logic [7:0] DIGIT_BASE  = 8'h00;
    localparam logic [7:0] BITMASK_OFS = 8'h40;
    localparam logic [7:0] BLINK_OFS   = 8'h44;
    localparam logic [7:0] BRIGHT_OFS  = 8'h48;
    localparam logic [7:0] RST_OFS     = 8'h4C;
    localparam logic [7:0] STATUS_OFS  = 8'h50;
    localparam logic [7:0] RAWMODE_OFS = 8'h54;

`ifdef HEX_DISP_SB_RAW_SEG_EN
    localparam int DIGIT_W = 7;
`else
    localparam int DIGIT_W = 4;
`endif

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h00;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_disp_scan.sv
// Scan, brightness PWM and blink engine with registered active-low display outputs.
// HEX_DISP_SB_RAW_SEG_EN adds a per-digit raw segment bypass of the decoder.
module hex_disp_scan
    import hex_disp_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 10000,
    parameter int BLINK_LOG2 = 24
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [DIGITS-1:0][DIGIT_W-1:0]   digits_i,
    input  logic [DIGITS-1:0]                mask_i,
    input  logic [DIGITS-1:0]                blink_i,
`ifdef HEX_DISP_SB_RAW_SEG_EN
    input  logic [DIGITS-1:0]                raw_i,
`endif
    input  logic [3:0]                       bright_i,
    output logic [3:0]                       idx_o,
    output logic [6:0]                       hex_led_o,
    output logic [DIGITS-1:0]                hex_sel_o
);

    localparam int                SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [3:0]        IDX_LAST  = 4'(DIGITS - 1);

    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [3:0]            pwm_q, pwm_d;
    logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;
    logic [6:0]            led_q, led_d;
    logic [DIGITS-1:0]     sel_q, sel_d;

    logic [DIGIT_W-1:0]    cur_digit;
    logic                  cur_en;
    logic                  cur_blink;
    logic [DIGITS-1:0]     cur_onehot;
    logic [6:0]            cur_seg;
    logic                  lit;
`ifdef HEX_DISP_SB_RAW_SEG_EN
    logic                  cur_raw;
`endif

    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        idx_d       = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
        end
        pwm_d       = pwm_q + 4'd1;
        blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
    end

    // Select the attributes of the digit currently being scanned.
    always_comb begin
        cur_digit  = '0;
        cur_en     = 1'b0;
        cur_blink  = 1'b0;
        cur_onehot = '0;
`ifdef HEX_DISP_SB_RAW_SEG_EN
        cur_raw    = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 4'(i)) begin
                cur_digit     = digits_i[i];
                cur_en        = mask_i[i];
                cur_blink     = blink_i[i];
                cur_onehot[i] = 1'b1;
`ifdef HEX_DISP_SB_RAW_SEG_EN
                cur_raw       = raw_i[i];
`endif
            end
        end
    end

    always_comb begin
`ifdef HEX_DISP_SB_RAW_SEG_EN
        cur_seg = cur_raw ? cur_digit[6:0] : hex2seg(cur_digit[3:0]);
`else
        cur_seg = hex2seg(cur_digit);
`endif
        lit   = cur_en && (pwm_q <= bright_i) && !(cur_blink && blink_cnt_q[BLINK_LOG2-1]);
        sel_d = lit ? ~cur_onehot : '1;
        led_d = lit ? ~cur_seg : 7'h7F;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            pwm_q       <= '0;
            blink_cnt_q <= '0;
            led_q       <= 7'h7F;
            sel_q       <= '1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
            sel_q       <= sel_d;
        end
    end

    assign idx_o     = idx_q;
    assign hex_led_o = led_q;
    assign hex_sel_o = sel_q;

endmodule

// File: rtl/hex_disp_sb_ctrl.sv
// System-bus slave for an N-digit multiplexed 7-segment display: register file and read mux.
// HEX_DISP_SB_RAW_SEG_EN adds the RAWMODE register and 7-bit digit registers.
module hex_disp_sb_ctrl
    import hex_disp_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 10000,
    parameter int BLINK_LOG2 = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              write_enable_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       write_data_i,
    output logic [31:0]       read_data_o,
    output logic [6:0]        hex_led_o,
    output logic [DIGITS-1:0] hex_sel_o
);

    logic [7:0]                      addr;
    logic                            wr_en;
    logic                            rd_en;
    logic                            unused_addr_hi;
    logic [DIGITS-1:0][DIGIT_W-1:0]  digit_q, digit_d;
    logic [DIGITS-1:0]               mask_q, mask_d;
    logic [DIGITS-1:0]               blink_q, blink_d;
    logic [3:0]                      bright_q, bright_d;
    logic [31:0]                     read_data_q, read_data_d;
    logic [3:0]                      scan_idx;
`ifdef HEX_DISP_SB_RAW_SEG_EN
    logic [DIGITS-1:0]               raw_q, raw_d;
`endif

    assign addr           = addr_i[7:0];
    assign unused_addr_hi = ^addr_i[31:8];
    assign wr_en          = req_i & write_enable_i;
    assign rd_en          = req_i & ~write_enable_i;

    // The RST command only touches bus registers; the scan engine keeps running.
    always_comb begin
        digit_d  = digit_q;
        mask_d   = mask_q;
        blink_d  = blink_q;
        bright_d = bright_q;
`ifdef HEX_DISP_SB_RAW_SEG_EN
        raw_d    = raw_q;
`endif
        if (wr_en) begin
            if (addr == RST_OFS) begin
                if (write_data_i == 32'd1) begin
                    digit_d  = '0;
                    mask_d   = '1;
                    blink_d  = '0;
                    bright_d = 4'hF;
`ifdef HEX_DISP_SB_RAW_SEG_EN
                    raw_d    = '0;
`endif
                end
            end else if (addr == BITMASK_OFS) begin
                mask_d = write_data_i[DIGITS-1:0];
            end else if (addr == BLINK_OFS) begin
                blink_d = write_data_i[DIGITS-1:0];
            end else if (addr == BRIGHT_OFS) begin
                bright_d = write_data_i[3:0];
`ifdef HEX_DISP_SB_RAW_SEG_EN
            end else if (addr == RAWMODE_OFS) begin
                raw_d = write_data_i[DIGITS-1:0];
`endif
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (addr == DIGIT_BASE + 8'(4 * i)) begin
                        digit_d[i] = write_data_i[DIGIT_W-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        if (rd_en) begin
            read_data_d = '0;
            if (addr == BITMASK_OFS) begin
                read_data_d = 32'(mask_q);
            end else if (addr == BLINK_OFS) begin
                read_data_d = 32'(blink_q);
            end else if (addr == BRIGHT_OFS) begin
                read_data_d = 32'(bright_q);
            end else if (addr == STATUS_OFS) begin
                read_data_d = 32'(scan_idx);
`ifdef HEX_DISP_SB_RAW_SEG_EN
            end else if (addr == RAWMODE_OFS) begin
                read_data_d = 32'(raw_q);
`endif
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (addr == DIGIT_BASE + 8'(4 * i)) begin
                        read_data_d = 32'(digit_q[i]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            digit_q     <= '0;
            mask_q      <= '1;
            blink_q     <= '0;
            bright_q    <= 4'hF;
            read_data_q <= '0;
`ifdef HEX_DISP_SB_RAW_SEG_EN
            raw_q       <= '0;
`endif
        end else begin
            digit_q     <= digit_d;
            mask_q      <= mask_d;
            blink_q     <= blink_d;
            bright_q    <= bright_d;
            read_data_q <= read_data_d;
`ifdef HEX_DISP_SB_RAW_SEG_EN
            raw_q       <= raw_d;
`endif
        end
    end

    assign read_data_o = read_data_q;

    hex_disp_scan #(
        .DIGITS     (DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_LOG2 (BLINK_LOG2)
    ) u_scan (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .digits_i   (digit_q),
        .mask_i     (mask_q),
        .blink_i    (blink_q),
`ifdef HEX_DISP_SB_RAW_SEG_EN
        .raw_i      (raw_q),
`endif
        .bright_i   (bright_q),
        .idx_o      (scan_idx),
        .hex_led_o  (hex_led_o),
        .hex_sel_o  (hex_sel_o)
    );

endmodule

// File: tb/tb_hex_disp_sb_ctrl.sv
// Scoreboard bench for hex_disp_sb_ctrl: a time-indexed reference model predicts every
// display cycle and every read; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_hex_disp_sb_ctrl;

    localparam int DIGITS     = 8;
    localparam int SCAN_DIV   = 4;
    localparam int BLINK_LOG2 = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [6:0]  led;
    logic [7:0]  sel;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [14:0] disp_q[$];

    // Reference model state: bus registers plus cycles elapsed since reset release.
    logic [3:0] m_digit [DIGITS];
    logic [7:0] m_mask;
    logic [7:0] m_blink;
    logic [3:0] m_bright;
    int         cyc;
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex_disp_sb_ctrl #(
        .DIGITS     (DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_LOG2 (BLINK_LOG2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .write_enable_i (we),
        .addr_i         (addr),
        .write_data_i   (wdata),
        .read_data_o    (rdata),
        .hex_led_o      (led),
        .hex_sel_o      (sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Display expected t clock edges after reset release, from the scan rules.
    function automatic logic [14:0] model_disp(input int t);
        int         idx;
        int         pwm;
        bit         blink_phase;
        bit         is_lit;
        logic [7:0] s;
        idx         = (t / SCAN_DIV) % DIGITS;
        pwm         = t % 16;
        blink_phase = (t % (1 << BLINK_LOG2)) >= (1 << (BLINK_LOG2 - 1));
        is_lit      = m_mask[idx] && (pwm <= int'(m_bright)) && !(m_blink[idx] && blink_phase);
        s           = 8'hFF;
        if (is_lit) begin
            s[idx] = 1'b0;
            return {s, ~seg_tab[m_digit[idx]]};
        end
        return {8'hFF, 7'h7F};
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int ai;
        ai = int'(a);
        if (ai < 'h40 && ai % 4 == 0) begin
            if (ai / 4 < DIGITS) return 32'(m_digit[ai / 4]);
            return 32'h0;
        end
        case (a)
            8'h40:   return 32'(m_mask);
            8'h44:   return 32'(m_blink);
            8'h48:   return 32'(m_bright);
            8'h50:   return 32'((cyc / SCAN_DIV) % DIGITS);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0;
            for (int i = 0; i < DIGITS; i++) m_digit[i] <= 4'h0;
            m_mask   <= 8'hFF;
            m_blink  <= 8'h00;
            m_bright <= 4'hF;
            exp_q.delete();
            disp_q.delete();
        end else begin
            disp_q.push_back(model_disp(cyc));
            if (req && !we) exp_q.push_back(model_read(addr[7:0]));
            if (req && we) begin
                if (addr[7:0] == 8'h4C) begin
                    if (wdata == 32'd1) begin
                        for (int i = 0; i < DIGITS; i++) m_digit[i] <= 4'h0;
                        m_mask   <= 8'hFF;
                        m_blink  <= 8'h00;
                        m_bright <= 4'hF;
                    end
                end else if (addr[7:0] == 8'h40) begin
                    m_mask <= wdata[7:0];
                end else if (addr[7:0] == 8'h44) begin
                    m_blink <= wdata[7:0];
                end else if (addr[7:0] == 8'h48) begin
                    m_bright <= wdata[3:0];
                end else if (addr[7:0] < 8'h40 && addr[1:0] == 2'b00 && int'(addr[7:2]) < DIGITS) begin
                    m_digit[int'(addr[7:2])] <= wdata[3:0];
                end
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (disp_q.size() > 0) begin
                check("hex_sel_o", 32'(sel), 32'(disp_q[0][14:7]));
                check("hex_led_o", 32'(led), 32'(disp_q[0][6:0]));
                void'(disp_q.pop_front());
            end
            if (exp_q.size() > 0) begin
                check("read_data_o", rdata, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        req   = 1'b0;
        we    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req  = 1'b1;
        we   = 1'b0;
        addr = a;
        @(negedge clk);
        d    = rdata;
        req  = 1'b0;
    endtask

    task automatic wait_status(input logic [3:0] target, input string name);
        logic [31:0] d;
        bit          hit;
        hit = 1'b0;
        for (int k = 0; k < 64 && !hit; k++) begin
            bus_read(32'h50, d);
            if (d[3:0] == target) hit = 1'b1;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] hi;
        logic [7:0]  a;
        int          cnt;
        int          cnt2;
        int          op;

        rst   = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_read_data", rdata, 32'h0);
        check("reset_sel", 32'(sel), 32'hFF);
        check("reset_led", 32'(led), 32'h7F);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("pre_update_sel", 32'(sel), 32'hFF);

        bus_read(32'h40, d); check("reset_bitmask", d, 32'h0000_00FF);
        bus_read(32'h48, d); check("reset_bright", d, 32'h0000_000F);
        bus_read(32'h00, d); check("reset_digit0", d, 32'h0);

        bus_write(32'h0C, 32'hA);
        wait_status(4'd3, "status_reach_3");
        check("digit3_sel", 32'(sel), 32'hF7);
        check("digit3_led", 32'(led), 32'h08);
        repeat (31) @(negedge clk);
        bus_read(32'h50, d);
        check("status_period_32", d, 32'd3);

        bus_write(32'h40, 32'hFE);
        wait_status(4'd7, "status_reach_7");
        wait_status(4'd0, "status_reach_0");
        check("mask_slot0_sel", 32'(sel), 32'hFF);
        check("mask_slot0_led", 32'(led), 32'h7F);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mask_slot0_sel_hold", 32'(sel), 32'hFF);
        end
        bus_write(32'h40, 32'hFF);

        bus_write(32'h48, 32'h3);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (sel != 8'hFF) cnt++;
        end
        check("bright3_lit_cycles", 32'(cnt), 32'd4);
        bus_write(32'h48, 32'hF);

        bus_write(32'h44, 32'h05);
        cnt  = 0;
        cnt2 = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (sel == 8'hFE) cnt++;
            if (sel == 8'hFB) cnt2++;
        end
        check("blink_d0_lit", 32'(cnt), 32'd4);
        check("blink_d2_lit", 32'(cnt2), 32'd0);
        bus_write(32'h44, 32'h00);

        bus_write(32'h20, 32'hF);
        bus_read(32'h20, d); check("digit8_reads_0", d, 32'h0);
        bus_read(32'h54, d); check("rawmode_unmapped", d, 32'h0);
        bus_read(32'h4C, d); check("rst_reads_0", d, 32'h0);

        bus_write(32'h48, 32'h5);
        bus_write(32'h4C, 32'h2);
        bus_read(32'h48, d); check("rst2_no_effect", d, 32'h5);
        bus_write(32'h00, 32'h7);
        bus_write(32'h44, 32'h3);
        bus_write(32'h40, 32'h0F);
        bus_write(32'h4C, 32'h1);
        bus_read(32'h40, d); check("rst1_bitmask", d, 32'hFF);
        bus_read(32'h44, d); check("rst1_blink", d, 32'h0);
        bus_read(32'h48, d); check("rst1_bright", d, 32'hF);
        bus_read(32'h00, d); check("rst1_digit0", d, 32'h0);

        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 9);
            a  = 8'(4 * $urandom_range(0, 22));
            hi = $urandom;
            if (op < 4) begin
                bus_read({hi[23:0], a}, d);
            end else if (op < 8) begin
                d = $urandom;
                if (a == 8'h4C) d = ($urandom_range(0, 3) == 0) ? 32'd1 : 32'd2;
                bus_write({hi[23:0], a}, d);
            end else begin
                @(negedge clk);
            end
        end

        bus_write(32'h4C, 32'h1);
        bus_read(32'h48, d);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", 32'(sel), 32'hFF);
        check("async_rst_led", 32'(led), 32'h7F);
        check("async_rst_read_data", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(32'h50, d); check("status_after_rst", d, 32'h0);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_disp_sb_ctrl.md
Name: hex_disp_sb_ctrl

Overview:
Parametrised system-bus slave driving a multiplexed N-digit 7-segment display. It is the next generation of the 8-digit hex controller and adds:
- parametrised digit count
- an integrated scan engine
- per-digit blink
- 16-level brightness PWM
- a readable scan status
It sits on the peripheral bus next to the other *_sb_ctrl slaves.

Parameters:
DIGITS, 8, number of digits (1..16); width of hex_sel_o and of the mask registers.
SCAN_DIV, 10000, clock cycles each digit stays selected (>=2).
BLINK_LOG2, 24, width of free-running blink counter; blink phase = its MSB.

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
req_i  input  1  bus request
write_enable_i  input  1  1 = write, 0 = read (qualified by req_i)
addr_i  input  32  byte address; only addr_i[7:0] decoded
write_data_i  input  32  write data
read_data_o  output  32  registered read data
hex_led_o  output  7  segments {g,f,e,d,c,b,a}, active-low
hex_sel_o  output  DIGITS  digit selects, active-low

Behaviour:
- Reset (async, rst_i=1):
  - Bus registers: digit regs = 0, BITMASK = all ones, BLINK = 0, BRIGHT = 15.
  - Scan index = 0; scan/PWM/blink counters = 0.
  - Outputs: read_data_o = 0, hex_led_o = 7'h7F, hex_sel_o = all ones.
- Register map (addr_i[7:0]):
  - 0x00+4*i: DIGIT[i], i < DIGITS, bits[3:0].
  - 0x40: BITMASK[DIGITS-1:0]; 1 = digit enabled.
  - 0x44: BLINK[DIGITS-1:0]; 1 = digit blinks.
  - 0x48: BRIGHT[3:0].
  - 0x4C: RST, write-only; writing exactly 1 restores all bus registers to reset values. Any other value is ignored. Scan counters are not affected.
  - 0x50: STATUS, read-only; bits[3:0] = current scan index.
- Reads (req_i & !write_enable_i):
  - read_data_o is updated on the next clock edge; latency 1.
  - Unused bits are zero-extended.
  - Unmapped addresses, DIGIT[i] with i >= DIGITS, and RST all read 0.
  - read_data_o holds its value when there is no read.
- Writes (req_i & write_enable_i):
  - Take effect on the clock edge; extra write_data_i bits are truncated.
  - Writes to unmapped addresses and to STATUS are ignored.
- Scan engine:
  - scan_cnt counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and the index advances, going DIGITS-1 -> 0.
  - Digits are not skipped; a disabled digit simply remains dark during its slot.
- Brightness: 4-bit pwm_cnt increments every clock and wraps. The digit is lit only while pwm_cnt <= BRIGHT, so BRIGHT = 15 is always on and BRIGHT = 0 gives 1/16 duty.
- Blink: blink_cnt is free-running. When MSB = 1, digits with their BLINK bit set are dark.
- Lit condition: BITMASK[idx] & pwm_ok & !(BLINK[idx] & blink_msb).
  - Lit: hex_sel_o has only bit idx = 0, and hex_led_o = ~decode(DIGIT[idx]).
  - Dark: hex_sel_o all ones and hex_led_o = 7'h7F.
  - Outputs are registered, 1 cycle behind the index and counters.
- Decode table (active-high gfedcba), digits 0..F: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
- Simultaneous events:
  - A write to DIGIT[idx] on the cycle before the output register updates is displayed on the next update.
  - A read and a write in the same cycle is impossible, because write_enable_i selects one.
- Reset mid-scan: the index returns to 0 immediately and all outputs go dark asynchronously.

Optional Feature:
Macro HEX_DISP_SB_RAW_SEG_EN.
- Defined:
  - Register 0x54 RAWMODE[DIGITS-1:0] is added; reset value 0; the RST command clears it.
  - DIGIT registers widen to 7 bits.
  - A digit with its RAWMODE bit set drives hex_led_o = ~DIGIT[i][6:0] directly, bypassing decode.
  - A digit with its RAWMODE bit clear uses DIGIT[i][3:0] through the decoder.
- Undefined: 0x54 is unmapped and reads 0; DIGIT registers are 4 bits.

Decomposition:
- Package hex_disp_pkg:
  - Register offset constants (DIGIT_BASE, BITMASK_OFS, BLINK_OFS, BRIGHT_OFS, RST_OFS, STATUS_OFS, RAWMODE_OFS).
  - Segment-decode function hex2seg(logic [3:0]) returning logic [6:0].
- Sub-module hex_disp_scan holds the scan/PWM/blink counters, lit logic and output registers. It is parametrised by DIGITS, SCAN_DIV and BLINK_LOG2.
- The top level holds only the bus register file and read mux.

Test Plan:
- Reset, then read 0x40, 0x48, 0x00 -> 0x000000FF, 0x0000000F, 0; outputs all ones until the first registered update.
- SCAN_DIV=4, DIGITS=8:
  - Write DIGIT[3] = 0xA, then wait until STATUS = 3.
  - Required: hex_sel_o = 8'hF7 and hex_led_o = ~7'h77 = 7'h08; the index returns to 0 after 32 cycles.
- Write BITMASK = 0xFE, hold index 0 -> hex_sel_o = 0xFF and hex_led_o = 7'h7F throughout slot 0.
- Write BRIGHT = 3 -> within one slot the digit is lit exactly 4 of every 16 cycles.
- BLINK_LOG2=4, write BLINK = 0x01 -> digit 0 is dark whenever blink_cnt >= 8.
- Checks:
  - Write DIGIT[8] with DIGITS=8 -> ignored; reads 0.
  - Write RST with 2 -> no change; write RST with 1 -> all registers back at reset values.
  - Assert rst_i mid-slot -> outputs dark in the same cycle and STATUS = 0 afterwards.
